seq_reco_mc: RTL and testbench

SEQ_RECO_MC -- requirements
Module: seq_reco_mc

---
 rtl/seq_reco_mc.sv | 156 +++++++++++++++
 tb/tb_seq_reco_mc.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seq_reco_mc.sv
// seq_reco_mc: multi-channel stochastic bitstream recorrelator.
// Each channel keeps a signed counter of deferred ones: c>0 counts
// held-back X ones, and c<0 counts held-back Y ones. Unpaired ones are
// stored and released later, so the overlap of the X and Y bitstreams is
// maximised (mode 0) or minimised (mode 1) without changing how many ones
// each stream carries in total.
module seq_reco_mc #(
  parameter int DEPTH = 1,
  parameter int CH    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          mode,
  input  logic          flush,
  input  logic [CH-1:0] x,
  input  logic [CH-1:0] y,
  output logic [CH-1:0] x_reco_r,
  output logic [CH-1:0] y_reco_r,
  output logic          valid_r,
  output logic          busy
);

  localparam int CW = $clog2(DEPTH + 1) + 1;
  localparam logic signed [CW-1:0] C_MAX  = DEPTH[CW-1:0];
  localparam logic signed [CW-1:0] C_MIN  = -C_MAX;
  localparam logic signed [CW-1:0] C_ZERO = {CW{1'b0}};
  localparam logic signed [CW-1:0] C_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic signed [CW-1:0] c_r     [CH];
  logic signed [CW-1:0] c_nxt_s [CH];
  logic [CH-1:0]        nz_s;
  logic [CH-1:0]        xo_s;
  logic [CH-1:0]        yo_s;
  logic                 m_q_r;
  logic                 mode_eff_s;

  // Flag every channel that still holds deferred bits
  always_comb begin
    nz_s = {CH{1'b0}};
    for (int i = 0; i < CH; i++) begin
      nz_s[i] = (c_r[i] != C_ZERO);
    end
  end

  assign busy = |nz_s;

  // A new mode can only take effect once every channel is empty; when all
  // channels are empty the requested mode applies on that very cycle
  always_comb begin
    if (busy) begin
      mode_eff_s = m_q_r;
    end else begin
      mode_eff_s = mode;
    end
  end

  // Per-channel output bits and counter update (flush wins over en)
  always_comb begin
    xo_s = {CH{1'b0}};
    yo_s = {CH{1'b0}};
    for (int i = 0; i < CH; i++) begin
      c_nxt_s[i] = c_r[i];
      if (flush) begin
        if (c_r[i] > C_ZERO) begin
          xo_s[i]    = 1'b1;
          c_nxt_s[i] = c_r[i] - C_ONE;
        end else if (c_r[i] < C_ZERO) begin
          yo_s[i]    = 1'b1;
          c_nxt_s[i] = c_r[i] + C_ONE;
        end else begin
          c_nxt_s[i] = C_ZERO;
        end
      end else if (en) begin
        if (!mode_eff_s) begin
          case ({x[i], y[i]})
            2'b10: begin
              if (c_r[i] < C_ZERO) begin
                xo_s[i]    = 1'b1;
                yo_s[i]    = 1'b1;
                c_nxt_s[i] = c_r[i] + C_ONE;
              end else if (c_r[i] < C_MAX) begin
                c_nxt_s[i] = c_r[i] + C_ONE;
              end else begin
                xo_s[i] = 1'b1;
              end
            end
            2'b01: begin
              if (c_r[i] > C_ZERO) begin
                xo_s[i]    = 1'b1;
                yo_s[i]    = 1'b1;
                c_nxt_s[i] = c_r[i] - C_ONE;
              end else if (c_r[i] > C_MIN) begin
                c_nxt_s[i] = c_r[i] - C_ONE;
              end else begin
                yo_s[i] = 1'b1;
              end
            end
            default: begin
              xo_s[i] = x[i];
              yo_s[i] = y[i];
            end
          endcase
        end else begin
          case ({x[i], y[i]})
            2'b11: begin
              if (c_r[i] < C_MAX) begin
                yo_s[i]    = 1'b1;
                c_nxt_s[i] = c_r[i] + C_ONE;
              end else begin
                xo_s[i] = 1'b1;
                yo_s[i] = 1'b1;
              end
            end
            2'b00: begin
              if (c_r[i] > C_ZERO) begin
                xo_s[i]    = 1'b1;
                c_nxt_s[i] = c_r[i] - C_ONE;
              end else begin
                c_nxt_s[i] = c_r[i];
              end
            end
            default: begin
              xo_s[i] = x[i];
              yo_s[i] = y[i];
            end
          endcase
        end
      end else begin
        c_nxt_s[i] = c_r[i];
      end
    end
  end

  // Counter, mode and registered output state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        c_r[i] <= C_ZERO;
      end
      x_reco_r <= {CH{1'b0}};
      y_reco_r <= {CH{1'b0}};
      valid_r  <= 1'b0;
      m_q_r    <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        c_r[i] <= c_nxt_s[i];
      end
      x_reco_r <= xo_s;
      y_reco_r <= yo_s;
      valid_r  <= flush | en;
      m_q_r    <= mode_eff_s;
    end
  end

endmodule

// File: tb/tb_seq_reco_mc.sv
// tb_seq_reco_mc: directed vector table on a DEPTH=1/CH=1 instance, plus
// saturation/drain and random conservation sequences on a DEPTH=4/CH=4 one.
module tb_seq_reco_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DEPTH=1, CH=1
  logic       rst, en, mode, flush;
  logic [0:0] x, y, xr, yr;
  logic       v, b;

  seq_reco_mc #(.DEPTH(1), .CH(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .flush(flush),
    .x(x), .y(y), .x_reco_r(xr), .y_reco_r(yr), .valid_r(v), .busy(b)
  );

  // Instance B: DEPTH=4, CH=4
  logic       rst2, en2, mode2, flush2;
  logic [3:0] x2, y2, xr2, yr2;
  logic       v2, b2;

  seq_reco_mc #(.DEPTH(4), .CH(4)) dut_b (
    .clk(clk), .rst(rst2), .en(en2), .mode(mode2), .flush(flush2),
    .x(x2), .y(y2), .x_reco_r(xr2), .y_reco_r(yr2), .valid_r(v2), .busy(b2)
  );

  typedef struct {
    logic rst, en, mode, flush, x, y;
    logic ex, ey, ev, eb;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, e, m, f, xi, yi, ex, ey, ev, eb);
    vec_t t;
    t.rst = r; t.en = e; t.mode = m; t.flush = f; t.x = xi; t.y = yi;
    t.ex = ex; t.ey = ey; t.ev = ev; t.eb = eb;
    return t;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[28];
    int   in_cnt[4];
    int   out_cnt[4];
    int   diff;
    int   any_stored;

    //              rst en md fl x  y   ex ey ev eb
    vecs[0]  = mk(1, 1, 0, 0, 1, 1,  0, 0, 0, 0); // reset ignores inputs
    vecs[1]  = mk(0, 1, 0, 0, 1, 0,  0, 0, 1, 1); // store X one
    vecs[2]  = mk(0, 1, 0, 0, 0, 1,  1, 1, 1, 0); // pair released
    vecs[3]  = mk(0, 1, 0, 0, 1, 0,  0, 0, 1, 1);
    vecs[4]  = mk(0, 1, 0, 0, 1, 0,  1, 0, 1, 1); // c==DEPTH saturates
    vecs[5]  = mk(0, 1, 0, 0, 0, 0,  0, 0, 1, 1);
    vecs[6]  = mk(0, 0, 0, 0, 1, 1,  0, 0, 0, 1); // en=0 gap, hold
    vecs[7]  = mk(0, 1, 0, 1, 0, 1,  1, 0, 1, 0); // flush drains X
    vecs[8]  = mk(0, 1, 0, 0, 0, 1,  0, 0, 1, 1); // store Y one
    vecs[9]  = mk(0, 1, 0, 0, 0, 1,  0, 1, 1, 1); // c==-DEPTH saturates
    vecs[10] = mk(0, 1, 0, 0, 1, 0,  1, 1, 1, 0);
    vecs[11] = mk(0, 1, 0, 1, 1, 1,  0, 0, 1, 0); // flush with c==0
    vecs[12] = mk(0, 1, 0, 0, 0, 1,  0, 0, 1, 1);
    vecs[13] = mk(0, 0, 0, 1, 0, 0,  0, 1, 1, 0); // flush drains Y
    vecs[14] = mk(0, 1, 1, 0, 1, 1,  0, 1, 1, 1); // negative mode
    vecs[15] = mk(0, 1, 1, 0, 0, 0,  1, 0, 1, 0);
    vecs[16] = mk(0, 1, 1, 0, 1, 1,  0, 1, 1, 1);
    vecs[17] = mk(0, 1, 1, 0, 1, 1,  1, 1, 1, 1); // negative saturation
    vecs[18] = mk(0, 1, 1, 0, 1, 0,  1, 0, 1, 1); // unpaired passes
    vecs[19] = mk(0, 1, 0, 0, 1, 1,  1, 1, 1, 1); // mode held while busy
    vecs[20] = mk(0, 1, 0, 0, 0, 0,  1, 0, 1, 0);
    vecs[21] = mk(0, 1, 0, 0, 1, 1,  1, 1, 1, 0); // idle: positive again
    vecs[22] = mk(0, 1, 0, 0, 1, 0,  0, 0, 1, 1);
    vecs[23] = mk(0, 1, 1, 1, 0, 0,  1, 0, 1, 0); // flush under new mode
    vecs[24] = mk(0, 1, 1, 0, 1, 1,  0, 1, 1, 1); // new mode now active
    vecs[25] = mk(1, 1, 0, 0, 1, 0,  0, 0, 0, 0); // mid-stream reset
    vecs[26] = mk(0, 0, 0, 0, 1, 1,  0, 0, 0, 0);
    vecs[27] = mk(0, 1, 0, 0, 1, 1,  1, 1, 1, 0); // first valid after reset

    rst = 1'b1; en = 1'b0; mode = 1'b0; flush = 1'b0; x = 1'b0; y = 1'b0;
    rst2 = 1'b1; en2 = 1'b0; mode2 = 1'b0; flush2 = 1'b0; x2 = 4'h0; y2 = 4'h0;
    repeat (2) @(posedge clk);

    // Directed table on instance A
    for (int k = 0; k < 28; k++) begin
      @(negedge clk);
      rst = vecs[k].rst; en = vecs[k].en; mode = vecs[k].mode;
      flush = vecs[k].flush; x[0] = vecs[k].x; y[0] = vecs[k].y;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_x", k), int'(xr[0]), int'(vecs[k].ex));
      chk($sformatf("v%0d_y", k), int'(yr[0]), int'(vecs[k].ey));
      chk($sformatf("v%0d_valid", k), int'(v), int'(vecs[k].ev));
      chk($sformatf("v%0d_busy", k), int'(b), int'(vecs[k].eb));
    end

    // Instance B: fill channel 0 past DEPTH=4, then flush it empty
    @(negedge clk);
    rst2 = 1'b0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      en2 = 1'b1; mode2 = 1'b0; flush2 = (k >= 6);
      x2 = (k < 6) ? 4'b0001 : 4'b0000;
      y2 = 4'b0000;
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d_x", k), int'(xr2[0]),
          int'(k == 4 || k == 5 || (k >= 6 && k <= 9)));
      chk($sformatf("sat%0d_y", k), int'(yr2), 0);
      chk($sformatf("sat%0d_busy", k), int'(b2), int'(k < 9));
      chk($sformatf("sat%0d_valid", k), int'(v2), 1);
    end

    // Instance B: random streams, ones conservation every cycle
    @(negedge clk);
    rst2 = 1'b1;
    @(posedge clk);
    #1;
    chk("b_reset_busy", int'(b2), 0);
    chk("b_reset_valid", int'(v2), 0);
    for (int c = 0; c < 4; c++) begin
      in_cnt[c] = 0;
      out_cnt[c] = 0;
    end
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      rst2 = 1'b0;
      en2 = ($urandom_range(0, 9) < 8);
      flush2 = ($urandom_range(0, 9) == 0);
      mode2 = ($urandom_range(0, 3) == 0) ? ~mode2 : mode2;
      x2 = 4'($urandom);
      y2 = 4'($urandom);
      @(posedge clk);
      #1;
      any_stored = 0;
      for (int c = 0; c < 4; c++) begin
        if (en2 && !flush2) begin
          in_cnt[c] += int'(x2[c]) + int'(y2[c]);
        end
        out_cnt[c] += int'(xr2[c]) + int'(yr2[c]);
        diff = in_cnt[c] - out_cnt[c];
        chk($sformatf("r%0d_ch%0d_stored_in_range", k, c),
            int'(diff >= 0 && diff <= 4), 1);
        if (diff != 0) any_stored = 1;
      end
      chk($sformatf("r%0d_busy", k), int'(b2), any_stored);
      chk($sformatf("r%0d_valid", k), int'(v2), int'(en2 | flush2));
      if (!en2 && !flush2) begin
        chk($sformatf("r%0d_gap_out", k), int'({xr2, yr2}), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
